// File: rtl/coefficient_store.sv
// Four-entry FIR coefficient store with loader busy handshake (modwait).
// Define COEFF_STORE_ERR_EN to enable the sticky err flag for loads seen while busy.
module coefficient_store #(
    parameter int BUSY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load_coeff,
    input  logic [1:0]  coefficient_num,
    input  logic [15:0] coeff_data,
    output logic        modwait,
    output logic [15:0] f0_coeff,
    output logic [15:0] f1_coeff,
    output logic [15:0] f2_coeff,
    output logic [15:0] f3_coeff,
    output logic        all_loaded,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(BUSY_CYCLES - 1);

    state_t     state;
    logic [3:0] busy_cnt;
    logic [3:0] mask;
    logic [3:0] mask_next;

    // Index 0 starts a fresh set; later indices accumulate.
    always_comb begin
        mask_next = mask | (4'b0001 << coefficient_num);
        if (coefficient_num == 2'd0) begin
            mask_next = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            busy_cnt   <= 4'd0;
            modwait    <= 1'b0;
            f0_coeff   <= 16'h0000;
            f1_coeff   <= 16'h0000;
            f2_coeff   <= 16'h0000;
            f3_coeff   <= 16'h0000;
            mask       <= 4'b0000;
            all_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_coeff) begin
                        case (coefficient_num)
                            2'd0:    f0_coeff <= coeff_data;
                            2'd1:    f1_coeff <= coeff_data;
                            2'd2:    f2_coeff <= coeff_data;
                            default: f3_coeff <= coeff_data;
                        endcase
                        mask       <= mask_next;
                        all_loaded <= &mask_next;
                        state      <= BUSY;
                        busy_cnt   <= CNT_INIT;
                        modwait    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (busy_cnt == 4'd0) begin
                        state   <= IDLE;
                        modwait <= 1'b0;
                    end else begin
                        busy_cnt <= busy_cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_cnt <= 4'd0;
                    modwait  <= 1'b0;
                end
            endcase
        end
    end

`ifdef COEFF_STORE_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err <= 1'b0;
        end else if (state == BUSY && load_coeff) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_coefficient_store.sv
// Directed bench for coefficient_store: BUSY_CYCLES=2 instance plus a
// BUSY_CYCLES=1 instance for back-to-back loading.
module tb_coefficient_store;

    logic        clk;
    logic        n_rst;
    logic        load_coeff;
    logic [1:0]  coefficient_num;
    logic [15:0] coeff_data;
    logic        modwait;
    logic [15:0] f0_coeff, f1_coeff, f2_coeff, f3_coeff;
    logic        all_loaded;
    logic        err;

    logic        ld1;
    logic [1:0]  idx1;
    logic [15:0] dat1;
    logic        modwait1;
    logic [15:0] g0, g1, g2, g3;
    logic        all_loaded1;
    logic        err1;

    int total = 0;
    int bad   = 0;
    logic exp_err;

    coefficient_store #(.BUSY_CYCLES(2)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .load_coeff(load_coeff),
        .coefficient_num(coefficient_num),
        .coeff_data(coeff_data),
        .modwait(modwait),
        .f0_coeff(f0_coeff),
        .f1_coeff(f1_coeff),
        .f2_coeff(f2_coeff),
        .f3_coeff(f3_coeff),
        .all_loaded(all_loaded),
        .err(err)
    );

    coefficient_store #(.BUSY_CYCLES(1)) dut1 (
        .clk(clk),
        .n_rst(n_rst),
        .load_coeff(ld1),
        .coefficient_num(idx1),
        .coeff_data(dat1),
        .modwait(modwait1),
        .f0_coeff(g0),
        .f1_coeff(g1),
        .f2_coeff(g2),
        .f3_coeff(g3),
        .all_loaded(all_loaded1),
        .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (modwait === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(modwait), 32'd0);
    endtask

    task automatic load(input logic [1:0] idx, input logic [15:0] d);
        wait_idle();
        load_coeff      = 1'b1;
        coefficient_num = idx;
        coeff_data      = d;
        tick();
        load_coeff = 1'b0;
    endtask

    initial begin
`ifdef COEFF_STORE_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        n_rst = 1'b0;
        load_coeff = 1'b0;
        coefficient_num = 2'd0;
        coeff_data = 16'h0;
        ld1 = 1'b0;
        idx1 = 2'd0;
        dat1 = 16'h0;
        tick();
        tick();
        check("rst_modwait", 32'(modwait), 32'd0);
        check("rst_f0", 32'(f0_coeff), 32'h0);
        check("rst_f3", 32'(f3_coeff), 32'h0);
        check("rst_all", 32'(all_loaded), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        n_rst = 1'b1;
        tick();

        // single load, modwait for exactly two cycles
        load(2'd0, 16'h1234);
        check("l0_f0", 32'(f0_coeff), 32'h1234);
        check("l0_mw1", 32'(modwait), 32'd1);
        check("l0_all", 32'(all_loaded), 32'd0);
        tick();
        check("l0_mw2", 32'(modwait), 32'd1);
        tick();
        check("l0_mw3", 32'(modwait), 32'd0);

        // full set
        load(2'd0, 16'h0001);
        check("set_all0", 32'(all_loaded), 32'd0);
        load(2'd1, 16'h0002);
        load(2'd2, 16'h0003);
        check("set_all2", 32'(all_loaded), 32'd0);
        load(2'd3, 16'h0004);
        check("set_all3", 32'(all_loaded), 32'd1);
        check("set_f0", 32'(f0_coeff), 32'h0001);
        check("set_f1", 32'(f1_coeff), 32'h0002);
        check("set_f2", 32'(f2_coeff), 32'h0003);
        check("set_f3", 32'(f3_coeff), 32'h0004);

        // restart with index 0
        load(2'd0, 16'hAAAA);
        check("rs_f0", 32'(f0_coeff), 32'hAAAA);
        check("rs_all", 32'(all_loaded), 32'd0);
        check("rs_f1", 32'(f1_coeff), 32'h0002);
        check("rs_f2", 32'(f2_coeff), 32'h0003);
        check("rs_f3", 32'(f3_coeff), 32'h0004);

        // load pulse in the last busy cycle is ignored
        load(2'd1, 16'h0B0B);
        check("ig_mw_a", 32'(modwait), 32'd1);
        check("ig_err_a", 32'(err), 32'd0);
        tick();
        check("ig_mw_b", 32'(modwait), 32'd1);
        load_coeff = 1'b1;
        coefficient_num = 2'd1;
        coeff_data = 16'hFFFF;
        tick();
        load_coeff = 1'b0;
        check("ig_mw_fall", 32'(modwait), 32'd0);
        check("ig_f1", 32'(f1_coeff), 32'h0B0B);
        check("ig_err", 32'(err), 32'(exp_err));
        tick();
        check("ig_mw_idle", 32'(modwait), 32'd0);
        check("ig_err_sticky", 32'(err), 32'(exp_err));

        // reset during busy
        load(2'd2, 16'h5555);
        check("ar_f2", 32'(f2_coeff), 32'h5555);
        check("ar_mw", 32'(modwait), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("ar_mw0", 32'(modwait), 32'd0);
        check("ar_f2_0", 32'(f2_coeff), 32'h0);
        check("ar_f0_0", 32'(f0_coeff), 32'h0);
        check("ar_all", 32'(all_loaded), 32'd0);
        check("ar_err", 32'(err), 32'd0);
        #3;
        n_rst = 1'b1;
        tick();
        load(2'd3, 16'h7777);
        check("ar_f3", 32'(f3_coeff), 32'h7777);
        check("ar_mw_new", 32'(modwait), 32'd1);
        check("ar_all_new", 32'(all_loaded), 32'd0);
        wait_idle();

        // BUSY_CYCLES=1: a load every second cycle
        for (int i = 0; i < 4; i++) begin
            ld1 = 1'b1;
            idx1 = 2'(i);
            dat1 = 16'h0100 + 16'(i);
            tick();
            ld1 = 1'b0;
            check("bb_mw_hi", 32'(modwait1), 32'd1);
            tick();
            check("bb_mw_lo", 32'(modwait1), 32'd0);
        end
        check("bb_g0", 32'(g0), 32'h0100);
        check("bb_g1", 32'(g1), 32'h0101);
        check("bb_g2", 32'(g2), 32'h0102);
        check("bb_g3", 32'(g3), 32'h0103);
        check("bb_all", 32'(all_loaded1), 32'd1);
        check("bb_err", 32'(err1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
